// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, op width and FSM state encoding for alu_multicycle (MUL state only with ALU_MUL_EN)
package alu_pkg;
   localparam int ALU_OP_W = 4;
   localparam logic [ALU_OP_W-1:0] OP_AND = 4'd0;
   localparam logic [ALU_OP_W-1:0] OP_OR  = 4'd1;
   localparam logic [ALU_OP_W-1:0] OP_NOR = 4'd2;
   localparam logic [ALU_OP_W-1:0] OP_ADD = 4'd3;
   localparam logic [ALU_OP_W-1:0] OP_SUB = 4'd4;
   localparam logic [ALU_OP_W-1:0] OP_LUI = 4'd5;
   localparam logic [ALU_OP_W-1:0] OP_SLL = 4'd6;
   localparam logic [ALU_OP_W-1:0] OP_SRL = 4'd7;
   localparam logic [ALU_OP_W-1:0] OP_SRA = 4'd8;
   localparam logic [ALU_OP_W-1:0] OP_SLT = 4'd9;
   localparam logic [ALU_OP_W-1:0] OP_MUL = 4'd10;
`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DONE = 2'd2} alu_state_e;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DONE = 2'd2} alu_state_e;
`endif
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per clock, WIDTH iterations
module alu_mul_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] prod
);
   logic [WIDTH-1:0] mc, hi, lo;
   logic [CNT_W-1:0] cnt;
   logic             run;
   logic [WIDTH:0]   sum;
   // prod is the value after the current step, so the top registers it on the final edge
   always_comb begin
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
      prod = {sum, lo[WIDTH-1:1]};
      done = run && cnt == '0;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mc  <= '0;
         hi  <= '0;
         lo  <= '0;
         cnt <= '0;
         run <= 1'b0;
      end else if (start) begin
         mc  <= a;
         hi  <= '0;
         lo  <= b;
         cnt <= CNT_W'(WIDTH - 1);
         run <= 1'b1;
      end else if (run) begin
         {hi, lo} <= prod;
         cnt      <= cnt - 1'b1;
         run      <= cnt != '0;
      end
   end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU behind valid/ready; iterative MUL built only when ALU_MUL_EN is defined
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ALU_OP_W-1:0] op,
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    result,
   output logic [WIDTH-1:0]    result_hi,
   output logic                zero,
   output logic                overflow,
   output logic                busy
);
   alu_state_e       state, state_n;
   logic             accept, big, alu_ovf;
   logic [WIDTH-1:0] sum, diff, sra_res, alu_res;
   logic [SHAMT_W-1:0] sh;
   assign in_ready  = state == ST_IDLE;
   assign out_valid = state == ST_DONE;
   assign accept    = in_valid && in_ready;
`ifdef ALU_MUL_EN
   logic               is_mul, mul_done;
   logic [2*WIDTH-1:0] mul_prod;
   assign is_mul = op == OP_MUL;
   assign busy   = state == ST_MUL;
   alu_mul_iter #(.WIDTH(WIDTH), .CNT_W(SHAMT_W)) u_mul (
      .clk   (clk),
      .reset (reset),
      .start (accept && is_mul),
      .a     (a),
      .b     (b),
      .done  (mul_done),
      .prod  (mul_prod)
   );
`else
   assign busy      = 1'b0;
   assign result_hi = '0;
`endif
   always_comb begin
      sh      = a[SHAMT_W-1:0];
      big     = a >= WIDTH'(WIDTH);
      sum     = a + b;
      diff    = a - b;
      sra_res = $signed(b) >>> sh;
      alu_res = '0;
      alu_ovf = 1'b0;
      case (op)
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_NOR: alu_res = ~(a | b);
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_LUI: alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         OP_SLL: alu_res = big ? '0 : b << sh;
         OP_SRL: alu_res = big ? '0 : b >> sh;
         OP_SRA: alu_res = big ? {WIDTH{b[WIDTH-1]}} : sra_res;
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         default: ;
      endcase
   end
   always_comb begin
      state_n = state;
      case (state)
`ifdef ALU_MUL_EN
         ST_IDLE: if (accept) state_n = is_mul ? ST_MUL : ST_DONE;
         ST_MUL:  if (mul_done) state_n = ST_DONE;
`else
         ST_IDLE: if (accept) state_n = ST_DONE;
`endif
         ST_DONE: if (out_ready) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_n;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result    <= '0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
`ifdef ALU_MUL_EN
         result_hi <= '0;
      end else if (mul_done) begin
         result    <= mul_prod[WIDTH-1:0];
         result_hi <= mul_prod[2*WIDTH-1:WIDTH];
         zero      <= mul_prod[WIDTH-1:0] == '0;
         overflow  <= 1'b0;
      end else if (accept && !is_mul) begin
         result_hi <= '0;
`else
      end else if (accept) begin
`endif
         result    <= alu_res;
         zero      <= alu_res == '0;
         overflow  <= alu_ovf;
      end
   end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: randomized and directed checks of alu_multicycle against a behavioural model
module tb_alu_multicycle;
`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, out_valid, out_ready, zero, overflow, busy;
   logic [3:0]  op;
   logic [31:0] a, b, result, result_hi;
   int          tests = 0, fails = 0;

   always #5 clk = ~clk;

   alu_multicycle #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .zero      (zero),
      .overflow  (overflow),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic [31:0] h,
                                 output logic z, output logic v);
      longint sx = longint'($signed(x));
      longint sy = longint'($signed(y));
      longint lim = 64'sh7FFF_FFFF;
      longint s;
      logic [63:0] p;
      r = 0;
      h = 0;
      v = 0;
      case (o)
         4'd0: r = x & y;
         4'd1: r = x | y;
         4'd2: r = ~(x | y);
         4'd3: begin s = sx + sy; r = s[31:0]; v = s > lim || s < -lim - 1; end
         4'd4: begin s = sx - sy; r = s[31:0]; v = s > lim || s < -lim - 1; end
         4'd5: r = y << 16;
         4'd6: r = x >= 32 ? 32'd0 : y << x;
         4'd7: r = x >= 32 ? 32'd0 : y >> x;
         4'd8: begin s = sy >>> (x >= 32 ? 32'd63 : x); r = s[31:0]; end
         4'd9: r = 32'(sx < sy);
         4'd10: if (MUL_EN) begin p = {32'd0, x} * {32'd0, y}; r = p[31:0]; h = p[63:32]; end
         default: r = 0;
      endcase
      z = r == 0;
   endfunction

   task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input bit hold);
      logic [31:0] er, eh;
      logic        ez, ev;
      int          lat, nbusy, nrdy;
      model(o, x, y, er, eh, ez, ev);
      @(negedge clk);
      in_valid = 1'b1;
      op = o;
      a = x;
      b = y;
      @(posedge clk);
      #1;
      in_valid = hold;
      op = hold ? 4'd3 : 4'($urandom);
      a = $urandom;
      b = $urandom;
      lat = 0;
      nbusy = 0;
      nrdy = 0;
      while (!out_valid && lat < 100) begin
         nbusy += int'(busy);
         nrdy  += int'(in_ready);
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", 64'(lat), (MUL_EN && o == 4'd10) ? 64'd32 : 64'd0);
      check("busy_cycles", 64'(nbusy), (MUL_EN && o == 4'd10) ? 64'd32 : 64'd0);
      check("ready_while_busy", 64'(nrdy + int'(in_ready)), 64'd0);
      check("result", 64'(result), 64'(er));
      check("result_hi", 64'(result_hi), 64'(eh));
      check("zero", 64'(zero), 64'(ez));
      check("overflow", 64'(overflow), 64'(ev));
   endtask

   task automatic finish_op();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("idle_ready", 64'(in_ready), 64'd1);
      check("idle_valid", 64'(out_valid), 64'd0);
   endtask

   initial begin
      logic [3:0]  o;
      logic [31:0] x, y, er, eh;
      logic        ez, ev;
      logic [3:0]  dop [11] = '{4'd3, 4'd4, 4'd6, 4'd8, 4'd7, 4'd8, 4'd5, 4'd9, 4'd9, 4'd10, 4'd15};
      logic [31:0] da  [11] = '{32'h7FFF_FFFF, 32'd5, 32'd31, 32'd4, 32'd32, 32'd40, 32'd0,
                                32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h1234_5678};
      logic [31:0] db  [11] = '{32'd1, 32'd5, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001,
                                32'h8000_0001, 32'h1234_ABCD, 32'd1, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'h9ABC_DEF0};
      reset = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      op = 4'd0;
      a = 32'd0;
      b = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_result", 64'(result), 64'd0);
      check("rst_result_hi", 64'(result_hi), 64'd0);
      check("rst_flags", 64'({zero, overflow, out_valid, busy}), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      reset = 1'b1;
      run_op(4'd3, 32'd7, 32'd5, 1'b0);
      check("first_add", 64'(result), 64'd12);
      finish_op();
      for (int i = 0; i < 11; i++) begin
         run_op(dop[i], da[i], db[i], dop[i] == 4'd10);
         finish_op();
      end
      out_ready = 1'b0;
      x = $urandom;
      y = $urandom;
      model(4'd1, x, y, er, eh, ez, ev);
      run_op(4'd1, x, y, 1'b0);
      in_valid = 1'b1;
      op = 4'd3;
      repeat (5) begin
         @(posedge clk);
         #1;
         check("bp_result", 64'(result), 64'(er));
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_out_valid", 64'(out_valid), 64'd1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      finish_op();
      @(negedge clk);
      in_valid = 1'b1;
      op = MUL_EN ? 4'd10 : 4'd3;
      a = 32'hFFFF_0003;
      b = 32'h0001_0005;
      out_ready = MUL_EN;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_result", 64'(result), 64'd0);
      check("midrst_result_hi", 64'(result_hi), 64'd0);
      check("midrst_flags", 64'({zero, overflow, out_valid, busy}), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      reset = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         o = 4'($urandom);
         x = $urandom;
         y = $urandom;
         if (o inside {4'd6, 4'd7, 4'd8} && $urandom_range(0, 1) == 1) x = $urandom_range(0, 40);
         run_op(o, x, y, 1'b0);
         finish_op();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
